// File: rtl/sseg_text_buffer_ctrl.sv
// Eight-digit text line for the multiplexed seven-segment driver: right-entering
// scroll of pushed characters, backspace, swept clear and whole-display blink.
module sseg_text_buffer_ctrl #(
    parameter int unsigned BLINK_TICKS = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       push_dp,
    input  logic       backspace,
    input  logic       clear,
    input  logic       blink_en,
    output logic       ready,
    output logic [3:0] count,
    output logic       full,
    output logic [5:0] D0,
    output logic [5:0] D1,
    output logic [5:0] D2,
    output logic [5:0] D3,
    output logic [5:0] D4,
    output logic [5:0] D5,
    output logic [5:0] D6,
    output logic [5:0] D7
);

    typedef enum logic {IDLE, CLEARING} state_t;

    localparam logic [25:0] BLINK_LAST = 26'(BLINK_TICKS - 1);

    state_t      state, state_next;
    logic [5:0]  slots      [8];
    logic [5:0]  slots_next [8];
    logic [3:0]  count_next;
    logic [2:0]  idx, idx_next;
    logic        ready_next;
    logic [25:0] blink_cnt;
    logic        phase;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        slots_next = slots;
        count_next = count;
        idx_next   = idx;
        ready_next = ready;

        case (state)
            IDLE: begin
                if (clear) begin
                    count_next = 4'd0;
                    idx_next   = 3'd0;
                    ready_next = 1'b0;
                    state_next = CLEARING;
                end else if (backspace) begin
                    if (count != 4'd0) begin
                        for (int i = 0; i < 7; i++) slots_next[i] = slots[i+1];
                        slots_next[7] = 6'd0;
                        count_next    = count - 4'd1;
                    end
                end else if (push) begin
                    // Shifting toward D7 drops the oldest character when the line is full.
                    for (int i = 7; i > 0; i--) slots_next[i] = slots[i-1];
                    slots_next[0] = {1'b1, push_data, push_dp};
                    if (count != 4'd8) count_next = count + 4'd1;
                end
            end
            CLEARING: begin
                if (clear) begin
                    idx_next = 3'd0;
                end else begin
                    slots_next[idx] = 6'd0;
                    idx_next        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the digit slots are reset along with the control state so empty digits read blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < 8; i++) slots[i] <= 6'd0;
            count <= 4'd0;
            full  <= 1'b0;
            idx   <= 3'd0;
            ready <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= state_next;
            slots <= slots_next;
            count <= count_next;
            full  <= (count_next == 4'd8);
            idx   <= idx_next;
            ready <= ready_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            blink_cnt <= 26'd0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= 26'd0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 26'd1;
        end
    end

    // Only the enable bit blinks; hex and dp pass straight through.
    assign D0 = {slots[0][5] & phase, slots[0][4:0]};
    assign D1 = {slots[1][5] & phase, slots[1][4:0]};
    assign D2 = {slots[2][5] & phase, slots[2][4:0]};
    assign D3 = {slots[3][5] & phase, slots[3][4:0]};
    assign D4 = {slots[4][5] & phase, slots[4][4:0]};
    assign D5 = {slots[5][5] & phase, slots[5][4:0]};
    assign D6 = {slots[6][5] & phase, slots[6][4:0]};
    assign D7 = {slots[7][5] & phase, slots[7][4:0]};

endmodule

// File: tb/tb_sseg_text_buffer_ctrl.sv
// Self-checking bench for sseg_text_buffer_ctrl: directed scenarios plus random
// traffic compared each cycle against a queue-based model of the text line.
module tb_sseg_text_buffer_ctrl;

    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [3:0] push_data = 4'd0;
    logic       push_dp = 1'b0;
    logic       backspace = 1'b0;
    logic       clear = 1'b0;
    logic       blink_en = 1'b0;
    logic       ready;
    logic [3:0] count;
    logic       full;
    logic [5:0] D0, D1, D2, D3, D4, D5, D6, D7;

    int checks = 0;
    int errors = 0;

    // Model: characters newest-first, plus sweep progress and blink age.
    logic [5:0] chars[$];
    logic [7:0] blank_mask;
    int         sweep_pos;
    bit         clearing;
    bit         m_ready;
    int         en_cycles;

    sseg_text_buffer_ctrl #(.BLINK_TICKS(TICKS)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .push_dp(push_dp), .backspace(backspace), .clear(clear),
        .blink_en(blink_en), .ready(ready), .count(count), .full(full),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            chars.delete();
            blank_mask = 8'd0;
            sweep_pos  = 0;
            clearing   = 0;
            m_ready    = 1;
            en_cycles  = 0;
            return;
        end
        en_cycles = blink_en ? en_cycles + 1 : 0;
        if (clearing) begin
            if (clear) sweep_pos = 0;
            else begin
                blank_mask[sweep_pos] = 1'b1;
                sweep_pos++;
                if (sweep_pos == 8) begin
                    clearing = 0;
                    m_ready  = 1;
                    chars.delete();
                    blank_mask = 8'd0;
                end
            end
        end else if (clear) begin
            clearing  = 1;
            sweep_pos = 0;
            m_ready   = 0;
        end else if (backspace) begin
            if (chars.size() > 0) void'(chars.pop_front());
        end else if (push) begin
            chars.push_front({1'b1, push_data, push_dp});
            if (chars.size() > 8) void'(chars.pop_back());
        end
    endtask

    function automatic logic [47:0] exp_digits();
        logic [47:0] r;
        logic [5:0]  w;
        bit          ph;
        ph = ((en_cycles / TICKS) % 2) == 0;
        for (int i = 0; i < 8; i++) begin
            w = (i < chars.size() && !blank_mask[i]) ? chars[i] : 6'd0;
            w[5] = w[5] & ph;
            r[i*6 +: 6] = w;
        end
        return r;
    endfunction

    function automatic int exp_count();
        return clearing ? 0 : chars.size();
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("digits", {D7, D6, D5, D4, D3, D2, D1, D0}, exp_digits());
        check("count", count, exp_count());
        check("full", full, exp_count() == 8);
        check("ready", ready, m_ready);
        push = 0; backspace = 0; clear = 0; reset = 0;
    endtask

    task automatic do_push(input logic [3:0] d, input logic dp);
        push = 1; push_data = d; push_dp = dp;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
    endtask

    initial begin
        int ready_low;

        do_reset();
        check("reset_d0", D0, 6'd0);

        // Two pushes: newest enters at D0.
        do_push(4'h3, 1'b0);
        do_push(4'hA, 1'b1);
        check("push_d0", D0, 6'b110101);
        check("push_d1", D1, 6'b100110);

        // Ten pushes scroll 0x0 and 0x1 off the far end.
        do_reset();
        for (int i = 0; i < 10; i++) do_push(4'(i), 1'b0);
        check("wrap_d0", D0, 6'b110010);
        check("wrap_d7", D7, 6'b100100);
        check("wrap_full", full, 1'b1);

        // Backspace burst, final one hits an empty line.
        do_reset();
        for (int i = 0; i < 3; i++) do_push(4'(i + 5), 1'b1);
        for (int i = 0; i < 4; i++) begin backspace = 1; tick(); end
        check("bs_empty", count, 4'd0);

        // Clear wins over a simultaneous push; count the ready-low cycles.
        for (int i = 0; i < 5; i++) do_push(4'(i), 1'b0);
        clear = 1; push = 1; push_data = 4'hF;
        tick();
        ready_low = 1;
        for (int i = 0; i < 12 && ready == 1'b0; i++) begin
            push = 1; tick();
            if (ready == 1'b0) ready_low++;
        end
        check("clear_ready_low", ready_low, 8);

        // Clear restarted at sweep cycle 4.
        for (int i = 0; i < 4; i++) do_push(4'(i + 8), 1'b1);
        clear = 1; tick();
        idle(3);
        clear = 1; tick();
        ready_low = 1;
        for (int i = 0; i < 12 && ready == 1'b0; i++) begin
            tick();
            if (ready == 1'b0) ready_low++;
        end
        check("restart_ready_low", ready_low, 8);

        // Blink then release.
        do_push(4'h1, 1'b0);
        do_push(4'h2, 1'b1);
        blink_en = 1;
        idle(18);
        blink_en = 0;
        tick();
        check("unblink_d0", D0, 6'b100101);

        // Reset during a sweep while blinking.
        do_push(4'h7, 1'b0);
        blink_en = 1;
        idle(5);
        clear = 1; tick();
        idle(2);
        do_reset();
        blink_en = 0;
        check("rst_mid_ready", ready, 1'b1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            push      = (r < 45);
            push_data = 4'($urandom);
            push_dp   = 1'($urandom);
            backspace = ($urandom_range(0, 99) < 20);
            clear     = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 6) blink_en = ~blink_en;
            reset     = ($urandom_range(0, 999) < 5);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
